// File: rtl/scan_mux_pkg.sv
// Shared types and helpers for the sensor scan selector.
package scan_mux_pkg;

   typedef enum logic {
      S_MAN,
      S_SCAN
   } state_t;

   localparam logic MODE_MAN  = 1'b0;
   localparam logic MODE_SCAN = 1'b1;

   // Dwell counter must represent 0..dwell-1 without wrapping; never narrower than 1 bit.
   function automatic int cnt_width(input int dwell);
      int w;
      w = $clog2(dwell + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/rr_next_ch.sv
// Round-robin search for the next enabled channel after cur, wrapping past N_CH-1.
module rr_next_ch
   import scan_mux_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int SEL_W = 2
) (
   input  logic [SEL_W-1:0] cur,
   input  logic [N_CH-1:0]  ch_en,
   output logic [SEL_W-1:0] nxt,
   output logic             wrap,
   output logic             none_en
);

   logic             found;
   logic [SEL_W-1:0] cand;

   // Candidate k=N_CH is cur itself, so a lone enabled channel re-selects itself.
   always_comb begin
      nxt   = cur;
      found = 1'b0;
      cand  = '0;
      for (int k = 1; k <= N_CH; k++) begin
         cand = SEL_W'((int'(cur) + k) % N_CH);
         if (!found && ch_en[cand]) begin
            found = 1'b1;
            nxt   = cand;
         end
      end
      none_en = ~found;
      wrap    = found && (nxt <= cur);
   end

endmodule

// File: rtl/sensor_scan_mux.sv
// N-channel registered selector with manual select and autonomous dwell-based scan.
// Optional channel-enable mask in scan mode: define SCAN_CH_MASK_EN.
module sensor_scan_mux
   import scan_mux_pkg::*;
#(
   parameter int  N_CH  = 4,
   parameter int  W     = 1,
   parameter int  DWELL = 8,
   localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mode,
   input  logic [SEL_W-1:0]  sel,
   input  logic              hold,
`ifdef SCAN_CH_MASK_EN
   input  logic [N_CH-1:0]   ch_en,
`endif
   input  logic [N_CH*W-1:0] din,
   output logic [W-1:0]      dout,
   output logic [SEL_W-1:0]  ch_idx,
   output logic              sample_vld,
   output logic              scan_done
);

   localparam int               CNT_W    = cnt_width(DWELL);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
   localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N_CH - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [SEL_W-1:0] idx;
   logic [SEL_W-1:0] idx_nxt;
   logic [SEL_W-1:0] idx_first;
   logic             idx_wrap;
   logic             none_en;
   logic [W-1:0]     ch [N_CH];

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      assign ch[k] = din[k*W +: W];
   end

`ifdef SCAN_CH_MASK_EN
   rr_next_ch #(
      .N_CH  (N_CH),
      .SEL_W (SEL_W)
   ) u_rr (
      .cur     (idx),
      .ch_en   (ch_en),
      .nxt     (idx_nxt),
      .wrap    (idx_wrap),
      .none_en (none_en)
   );

   // Scan entry starts from the lowest enabled channel (0 when none are enabled).
   always_comb begin
      idx_first = '0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         if (ch_en[k]) idx_first = SEL_W'(k);
      end
   end
`else
   assign idx_nxt   = (idx == IDX_LAST) ? '0 : idx + SEL_W'(1);
   assign idx_wrap  = (idx == IDX_LAST);
   assign none_en   = 1'b0;
   assign idx_first = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_MAN;
         dout       <= '0;
         ch_idx     <= '0;
         sample_vld <= 1'b0;
         scan_done  <= 1'b0;
         cnt        <= '0;
         idx        <= '0;
      end else begin
         sample_vld <= 1'b0;
         scan_done  <= 1'b0;
         unique case (state)
            S_MAN: begin
               if (mode == MODE_SCAN) begin
                  state <= S_SCAN;
                  idx   <= idx_first;
                  cnt   <= '0;
               end else if (int'(sel) < N_CH) begin
                  dout       <= ch[sel];
                  ch_idx     <= sel;
                  sample_vld <= 1'b1;
               end else begin
                  dout <= '0;
               end
            end
            S_SCAN: begin
               // Mode change wins over hold; manual sampling resumes next cycle.
               if (mode == MODE_MAN) begin
                  state <= S_MAN;
               end else if (hold) begin
                  cnt <= cnt;
               end else if (none_en) begin
                  cnt <= '0;
               end else if (cnt == CNT_LAST) begin
                  dout       <= ch[idx];
                  ch_idx     <= idx;
                  sample_vld <= 1'b1;
                  scan_done  <= idx_wrap;
                  cnt        <= '0;
                  idx        <= idx_nxt;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= S_MAN;
         endcase
      end
   end

endmodule
